// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register and the PC-source mux select.
// Sequences boot, increment, load-use stall, ID redirect with IF flush, and halt.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] PC_INC       = 16'd1,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] newPC,
    input  logic        ID_branchTaken,
    input  logic [15:0] ID_PC,
    input  logic        stall,
    input  logic        halt,
    output logic [15:0] currentPC,
    output logic [15:0] seqPC,
    output logic        ID_HazardControl,
    output logic        IF_valid,
    output logic        IF_flush,
    output logic        halted,
    output logic [15:0] redirectCount
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_STALL,
        S_FLUSH,
        S_HALT
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_redirects;
    logic [1:0]  r_flush_cnt;
    logic [1:0]  w_flush_next;
    logic        w_load;
    logic        w_redirect;

    // Next-state, PC-load and redirect decode
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_redirect   = 1'b0;
        w_flush_next = r_flush_cnt;
        unique case (r_state)
            S_BOOT: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    w_next = S_HALT;
                end else if (stall) begin
                    w_next = S_STALL;
                end else if (ID_branchTaken) begin
                    w_redirect   = 1'b1;
                    w_load       = 1'b1;
                    w_flush_next = FLUSH_INIT;
                    w_next       = S_FLUSH;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_STALL: begin
                if (halt) begin
                    w_next = S_HALT;
                end else if (!stall) begin
                    w_next = S_RUN;
                end
            end
            S_FLUSH: begin
                w_load       = 1'b1;
                w_flush_next = r_flush_cnt - 2'd1;
                if (r_flush_cnt <= 2'd1) begin
                    w_next = S_RUN;
                end
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

    // State, PC, flush counter and redirect counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_flush_cnt <= 2'd0;
            r_redirects <= 16'd0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_flush_next;
            if (w_load) begin
                r_pc <= newPC;
            end
            if (w_redirect) begin
                r_redirects <= r_redirects + 16'd1;
            end
        end
    end

    assign currentPC        = r_pc;
    assign seqPC            = r_pc + PC_INC;
    assign ID_HazardControl = w_redirect;
    assign IF_valid         = (r_state == S_RUN) || (r_state == S_STALL) ||
                              (r_state == S_FLUSH);
    assign IF_flush         = (r_state == S_FLUSH);
    assign halted           = (r_state == S_HALT);
    assign redirectCount    = r_redirects;

    // The mux must hand back the ID target whenever a redirect is selected
    a_redirect_target : assert property (
        @(posedge clk) disable iff (!rst_n) w_redirect |-> (newPC == ID_PC)
    );

endmodule
